sbox_round_scheduler: RTL and testbench

//  Time-multiplexes one shared DES S-box lookup port across the eight S-box tables (sb1..sb8).

---
 rtl/sbox_round_scheduler_if.sv | 27 ++
 rtl/sbox_round_scheduler.sv | 107 ++++++++++
 tb/tb_sbox_round_scheduler.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sbox_round_scheduler_if.sv
// rtl/sbox_round_scheduler_if.sv - input word, shared S-box lookup port and packed output bundle
interface sbox_round_scheduler_if #(
  parameter int NUM_BOXES = 8,
  parameter int SB_IN_W   = 6,
  parameter int SB_OUT_W  = 4
);
  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_BOXES*SB_IN_W-1:0]  in_data;
  logic [2:0]                    sb_sel;
  logic [SB_IN_W-1:0]            sb_in;
  logic [SB_OUT_W-1:0]           sb_out;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_BOXES*SB_OUT_W-1:0] out_data;
  logic                          busy;

  modport slave (
    input  in_valid, in_data, sb_out, out_ready,
    output in_ready, sb_sel, sb_in, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, sb_out, out_ready,
    input  in_ready, sb_sel, sb_in, out_valid, out_data, busy
  );
endinterface

// File: rtl/sbox_round_scheduler.sv
// rtl/sbox_round_scheduler.sv - eight DES S-box lookups over one shared port; SBOX_PIPE_EN registers sb_out
module sbox_round_scheduler #(
  parameter int NUM_BOXES = 8,
  parameter int SB_IN_W   = 6,
  parameter int SB_OUT_W  = 4
) (
  input logic                   clk,
  input logic                   rst,
  sbox_round_scheduler_if.slave bus
);
  localparam int IN_W  = NUM_BOXES * SB_IN_W;
  localparam int OUT_W = NUM_BOXES * SB_OUT_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [2:0] LAST_K = 3'(NUM_BOXES - 1);

  logic [1:0]          state;
  logic [2:0]          k;
  logic [IN_W-1:0]     word;
  logic [OUT_W-1:0]    acc;
  logic [2:0]          sb_sel_q;
  logic [SB_IN_W-1:0]  sb_in_q;
  logic                capture;
  logic                finish;
  logic [SB_OUT_W-1:0] nibble;

`ifdef SBOX_PIPE_EN
  // Result of index k lands in sb_q one edge after issue; one extra drain cycle collects the last one.
  logic [SB_OUT_W-1:0] sb_q;
  logic                wr_en;
  logic                drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q  <= '0;
      wr_en <= 1'b0;
      drain <= 1'b0;
    end else begin
      sb_q  <= bus.sb_out;
      wr_en <= (state == LOOKUP) && !drain;
      drain <= (state == LOOKUP) && !drain && (k == LAST_K);
    end
  end

  assign capture = wr_en;
  assign nibble  = sb_q;
  assign finish  = drain;
`else
  assign capture = (state == LOOKUP);
  assign nibble  = bus.sb_out;
  assign finish  = (k == LAST_K);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      word     <= '0;
      acc      <= '0;
      sb_sel_q <= '0;
      sb_in_q  <= '0;
    end else begin
      // Shifting in from the bottom leaves S1's nibble in the top bits after eight captures.
      if (capture) begin
        acc <= {acc[OUT_W-SB_OUT_W-1:0], nibble};
      end
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state    <= LOOKUP;
            k        <= '0;
            acc      <= '0;
            sb_sel_q <= '0;
            sb_in_q  <= bus.in_data[IN_W-1 -: SB_IN_W];
            word     <= bus.in_data << SB_IN_W;
          end
        end
        LOOKUP: begin
          if (finish) begin
            state <= DONE;
            k     <= '0;
          end else if (k != LAST_K) begin
            k        <= k + 3'd1;
            sb_sel_q <= k + 3'd1;
            sb_in_q  <= word[IN_W-1 -: SB_IN_W];
            word     <= word << SB_IN_W;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = acc;
  assign bus.busy      = (state != IDLE);
  assign bus.sb_sel    = sb_sel_q;
  assign bus.sb_in     = sb_in_q;
endmodule

// File: tb/tb_sbox_round_scheduler.sv
// tb/tb_sbox_round_scheduler.sv - directed vector bench for sbox_round_scheduler with a DES S-box reference
module tb_sbox_round_scheduler;
`ifdef SBOX_PIPE_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 9;
`endif
  localparam int PERIOD = LAT + 1;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  sbox_round_scheduler_if bus ();

  sbox_round_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Standard DES tables, 64 nibbles each, row 0 column 0 in the top nibble.
  logic [255:0] sbt [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [3:0] sbox_ref(input logic [255:0] tbl, input logic [5:0] x);
    int idx;
    idx = int'({x[5], x[0]}) * 16 + int'(x[4:1]);
    return tbl[255 - 4 * idx -: 4];
  endfunction

  assign bus.sb_out = sbox_ref(sbt[bus.sb_sel], bus.sb_in);

  typedef struct {
    logic [47:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"},  64'(bus.in_ready),  64'd1);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".out_data"},  64'(bus.out_data),  64'd0);
    chk({tag, ".sb_sel"},    64'(bus.sb_sel),    64'd0);
    chk({tag, ".sb_in"},     64'(bus.sb_in),     64'd0);
    chk({tag, ".busy"},      64'(bus.busy),      64'd0);
  endtask

  task automatic run_word(input logic [47:0] d, input logic [31:0] exp, input string tag);
    logic [47:0] w;
    bit          trace_ok;
    bit          early;
    @(negedge clk);
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    w        = d;
    trace_ok = 1'b1;
    early    = 1'b0;
    for (int c = 1; c < LAT; c++) begin
      @(negedge clk);
      if (bus.out_valid) early = 1'b1;
      if (c <= 8) begin
        if (bus.sb_sel !== 3'(c - 1) || bus.sb_in !== w[47:42]) trace_ok = 1'b0;
        w = w << 6;
      end
    end
    chk({tag, ".early_valid"}, 64'(early), 64'd0);
    chk({tag, ".sb_trace"}, 64'(trace_ok), 64'd1);
    @(negedge clk);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, ".out_data"}, 64'(bus.out_data), 64'(exp));
  endtask

  initial begin
    logic [31:0] outs [2];
    int          nout;
    int          second_acc;
    bit          stable_ok;
    bit          quiet;

    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{48'h000000000000, 32'hEFA72C4D};
    vecs[1] = '{48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
    vecs[2] = '{48'h041041041041, 32'h03DDEAD1};
    vecs[3] = '{48'h820820820820, 32'h40DA4917};
    vecs[4] = '{48'h79E79E79E79E, 32'h7A8F9B17};
    vecs[5] = '{48'h03F03F03F03F, 32'hE9AE2D4B};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("post_reset");

    for (int i = 0; i < 6; i++) begin
      run_word(vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Back-pressure: DONE held with out_ready low, in_valid presented and ignored.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 48'h0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 48'hFFFFFFFFFFFF;
    stable_ok    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hEFA72C4D ||
          bus.in_ready !== 1'b0 || bus.busy !== 1'b1) stable_ok = 1'b0;
    end
    chk("bp.hold_stable", 64'(stable_ok), 64'd1);
    chk("bp.out_data", 64'(bus.out_data), 64'h0EFA72C4D);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    chk("bp.release_valid", 64'(bus.out_valid), 64'd0);
    chk("bp.release_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp.release_busy", 64'(bus.busy), 64'd0);

    // Reset while index 4 is on the lookup port.
    bus.in_valid = 1'b1;
    bus.in_data  = 48'hFFFFFFFFFFFF;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst.sb_sel_before", 64'(bus.sb_sel), 64'd4);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b1 & 1'b0;
    end
    chk("rst.no_out_valid", 64'(quiet), 64'd1);
    run_word(48'h0, 32'hEFA72C4D, "after_rst");

    // Back-to-back words with in_valid and out_ready held high.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 48'hFFFFFFFFFFFF;
    chk("b2b.in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_data = 48'h0;
    nout        = 0;
    second_acc  = -1;
    for (int c = 1; c <= 2 * PERIOD + 1; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (nout < 2) outs[nout] = bus.out_data;
        nout++;
      end
      if (bus.in_ready && bus.in_valid && second_acc < 0) begin
        second_acc = c;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
      end
    end
    chk("b2b.accept_gap", 64'(second_acc), 64'(PERIOD));
    chk("b2b.out_count", 64'(nout), 64'd2);
    chk("b2b.word1", 64'(outs[0]), 64'h0D9CE3DCB);
    chk("b2b.word2", 64'(outs[1]), 64'h0EFA72C4D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
